// File: rtl/bwzz_pkg.sv
// Shared definitions for the interrupt sequencer and the memory stage.
package bwzz_pkg;

  // Sequencer states: interrupt entry (DRAIN..VECTOR) and RTI return (RTI_DRAIN..RESUME).
  typedef enum logic [3:0] {
    IDLE      = 4'd0,
    DRAIN     = 4'd1,
    PUSH_HI   = 4'd2,
    PUSH_LO   = 4'd3,
    VECTOR    = 4'd4,
    RTI_DRAIN = 4'd5,
    POP_LO    = 4'd6,
    POP_HI    = 4'd7,
    RESUME    = 4'd8
  } seq_state_t;

  // Stack-pointer operation codes, decoded identically by the memory stage.
  localparam logic [1:0] SP_NONE = 2'b00;
  localparam logic [1:0] SP_PUSH = 2'b01;
  localparam logic [1:0] SP_POP  = 2'b10;

endpackage

// File: rtl/interrupt_sequencer.sv
// Interrupt entry / RTI return sequencer: freezes fetch, drains the pipe,
// pushes or pops the 32-bit return PC as two stack words, saves or restores
// the flags and redirects fetch.
module interrupt_sequencer
  import bwzz_pkg::*;
#(
  parameter int unsigned DRAIN_CYCLES = 3,
  parameter logic [31:0] VECTOR_PC    = 32'h0000_0020
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        interrupt,
  input  logic        branch_flush,
  input  logic        rti_decoded,
  input  logic [31:0] if_pc,
  input  logic        mem_ack,
  input  logic [15:0] mem_rdata,
  output logic        hold,
  output logic        mem_req,
  output logic        mem_we,
  output logic [15:0] mem_wdata,
  output logic [1:0]  sp_op,
  output logic        flags_save,
  output logic        flags_restore,
  output logic        pc_load,
  output logic [31:0] pc_load_value,
  output logic        busy
);

  localparam logic [3:0] LP_DRAIN = 4'(DRAIN_CYCLES);

  seq_state_t  r_state;
  seq_state_t  w_next;
  logic        r_pending;
  logic [31:0] r_ret_pc;
  logic [3:0]  r_drain_cnt;
  logic        w_accept;
  logic        w_drain_load;
  logic        w_drain_done;

  assign w_drain_done = (r_drain_cnt <= 4'd1);

  // State register; reset aborts any sequence in progress.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Next-state and Moore output decode (pc_load_value also looks at ret_pc).
  always_comb begin
    w_next        = r_state;
    w_accept      = 1'b0;
    w_drain_load  = 1'b0;
    hold          = 1'b1;
    busy          = 1'b1;
    mem_req       = 1'b0;
    mem_we        = 1'b0;
    mem_wdata     = '0;
    sp_op         = SP_NONE;
    flags_save    = 1'b0;
    flags_restore = 1'b0;
    pc_load       = 1'b0;
    pc_load_value = r_ret_pc;
    unique case (r_state)
      IDLE: begin
        hold = 1'b0;
        busy = 1'b0;
        // RTI wins over a pending interrupt; a flush defers acceptance so the
        // captured PC is the branch target rather than the flushed path.
        if (rti_decoded) begin
          w_next       = RTI_DRAIN;
          w_drain_load = 1'b1;
        end else if (r_pending && !branch_flush) begin
          w_next       = DRAIN;
          w_accept     = 1'b1;
          w_drain_load = 1'b1;
        end
      end
      DRAIN: begin
        if (w_drain_done) w_next = PUSH_HI;
      end
      PUSH_HI: begin
        mem_req   = 1'b1;
        mem_we    = 1'b1;
        sp_op     = SP_PUSH;
        mem_wdata = r_ret_pc[31:16];
        if (mem_ack) w_next = PUSH_LO;
      end
      PUSH_LO: begin
        mem_req   = 1'b1;
        mem_we    = 1'b1;
        sp_op     = SP_PUSH;
        mem_wdata = r_ret_pc[15:0];
        if (mem_ack) w_next = VECTOR;
      end
      VECTOR: begin
        pc_load       = 1'b1;
        flags_save    = 1'b1;
        pc_load_value = VECTOR_PC;
        w_next        = IDLE;
      end
      RTI_DRAIN: begin
        if (w_drain_done) w_next = POP_LO;
      end
      POP_LO: begin
        mem_req = 1'b1;
        sp_op   = SP_POP;
        if (mem_ack) w_next = POP_HI;
      end
      POP_HI: begin
        mem_req = 1'b1;
        sp_op   = SP_POP;
        if (mem_ack) w_next = RESUME;
      end
      RESUME: begin
        pc_load       = 1'b1;
        flags_restore = 1'b1;
        w_next        = IDLE;
      end
      default: begin
        w_next = IDLE;
      end
    endcase
  end

  // Pending latch: pulses merge; a pulse coinciding with accept is kept.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_pending <= 1'b0;
    end else begin
      r_pending <= interrupt | (r_pending & ~w_accept);
    end
  end

  // Drain counter: loaded on entry to either drain state, counts down to 1.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_drain_cnt <= '0;
    end else if (w_drain_load) begin
      r_drain_cnt <= LP_DRAIN;
    end else if (r_state == DRAIN || r_state == RTI_DRAIN) begin
      r_drain_cnt <= r_drain_cnt - 4'd1;
    end
  end

  // Return PC: captured on the first DRAIN cycle, rebuilt from two pops on RTI.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_ret_pc <= '0;
    end else if (r_state == DRAIN && r_drain_cnt == LP_DRAIN) begin
      r_ret_pc <= if_pc;
    end else if (r_state == POP_LO && mem_ack) begin
      r_ret_pc[15:0] <= mem_rdata;
    end else if (r_state == POP_HI && mem_ack) begin
      r_ret_pc[31:16] <= mem_rdata;
    end
  end

endmodule

// File: tb/tb_interrupt_sequencer.sv
// Bench for interrupt_sequencer: a beat-script model checked every cycle plus
// directed scenarios with hand-computed expectations.
module tb_interrupt_sequencer;

  localparam int unsigned DRAIN_CYCLES = 3;
  localparam logic [31:0] VECTOR_PC    = 32'h0000_0020;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        interrupt = 1'b0;
  logic        branch_flush = 1'b0;
  logic        rti_decoded = 1'b0;
  logic [31:0] if_pc = '0;
  logic        mem_ack = 1'b0;
  logic [15:0] mem_rdata = '0;
  logic        hold, mem_req, mem_we, flags_save, flags_restore, pc_load, busy;
  logic [15:0] mem_wdata;
  logic [1:0]  sp_op;
  logic [31:0] pc_load_value;

  interrupt_sequencer #(
    .DRAIN_CYCLES(DRAIN_CYCLES),
    .VECTOR_PC   (VECTOR_PC)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .interrupt    (interrupt),
    .branch_flush (branch_flush),
    .rti_decoded  (rti_decoded),
    .if_pc        (if_pc),
    .mem_ack      (mem_ack),
    .mem_rdata    (mem_rdata),
    .hold         (hold),
    .mem_req      (mem_req),
    .mem_we       (mem_we),
    .mem_wdata    (mem_wdata),
    .sp_op        (sp_op),
    .flags_save   (flags_save),
    .flags_restore(flags_restore),
    .pc_load      (pc_load),
    .pc_load_value(pc_load_value),
    .busy         (busy)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int base  = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // Stack memory responder: acks requests, optionally delaying the next access.
  int          ack_wait    = 0;
  int          first_delay = 0;
  logic [15:0] pop_words[2];
  int          pop_idx     = 0;

  task automatic tick();
    @(posedge clk);
    #1;
    if (mem_req) begin
      if (ack_wait < first_delay) begin
        mem_ack = 1'b0;
        ack_wait++;
      end else begin
        mem_ack     = 1'b1;
        ack_wait    = 0;
        first_delay = 0;
        if (!mem_we) begin
          mem_rdata = pop_words[pop_idx % 2];
          pop_idx++;
        end
      end
    end else begin
      mem_ack = 1'b0;
    end
    cyc++;
  endtask

  task automatic adv(input int k);
    while (cyc - base < k) tick();
  endtask

  task automatic go(input int k);
    adv(k);
    @(negedge clk);
  endtask

  // Model: a script of expected beats; memory beats wait for ack.
  typedef enum int {B_DFIRST, B_DRAIN, B_PHI, B_PLO, B_VEC, B_RDRAIN, B_POPLO, B_POPHI, B_RES} beat_t;
  beat_t       q[$];
  logic        m_pending = 1'b0;
  logic [31:0] m_ret_pc  = '0;

  always @(negedge clk) begin
    logic        e_hold, e_req, e_we, e_fs, e_fr, e_pcl, e_busy, acc;
    logic [15:0] e_wd;
    logic [1:0]  e_sp;
    logic [31:0] e_pcv;
    if (reset) begin
      q.delete();
      m_pending = 1'b0;
      m_ret_pc  = '0;
    end
    e_hold = 1'b0; e_req = 1'b0; e_we = 1'b0; e_fs = 1'b0; e_fr = 1'b0;
    e_pcl = 1'b0; e_busy = 1'b0; e_wd = '0; e_sp = 2'b00; e_pcv = m_ret_pc;
    if (q.size() > 0) begin
      e_hold = 1'b1;
      e_busy = 1'b1;
      case (q[0])
        B_PHI: begin e_req = 1'b1; e_we = 1'b1; e_sp = 2'b01; e_wd = m_ret_pc[31:16]; end
        B_PLO: begin e_req = 1'b1; e_we = 1'b1; e_sp = 2'b01; e_wd = m_ret_pc[15:0]; end
        B_VEC: begin e_pcl = 1'b1; e_fs = 1'b1; e_pcv = VECTOR_PC; end
        B_POPLO, B_POPHI: begin e_req = 1'b1; e_sp = 2'b10; end
        B_RES: begin e_pcl = 1'b1; e_fr = 1'b1; end
        default: ;
      endcase
    end
    chk("model_outputs",
        64'({hold, mem_req, mem_we, mem_wdata, sp_op, flags_save, flags_restore, pc_load, pc_load_value, busy}),
        64'({e_hold, e_req, e_we, e_wd, e_sp, e_fs, e_fr, e_pcl, e_pcv, e_busy}));
    if (!reset) begin
      acc = 1'b0;
      if (q.size() == 0) begin
        if (rti_decoded) begin
          repeat (DRAIN_CYCLES) q.push_back(B_RDRAIN);
          q.push_back(B_POPLO); q.push_back(B_POPHI); q.push_back(B_RES);
        end else if (m_pending && !branch_flush) begin
          acc = 1'b1;
          q.push_back(B_DFIRST);
          repeat (DRAIN_CYCLES - 1) q.push_back(B_DRAIN);
          q.push_back(B_PHI); q.push_back(B_PLO); q.push_back(B_VEC);
        end
      end else begin
        case (q[0])
          B_DFIRST: begin m_ret_pc = if_pc; void'(q.pop_front()); end
          B_PHI, B_PLO: if (mem_ack) void'(q.pop_front());
          B_POPLO: if (mem_ack) begin m_ret_pc[15:0] = mem_rdata; void'(q.pop_front()); end
          B_POPHI: if (mem_ack) begin m_ret_pc[31:16] = mem_rdata; void'(q.pop_front()); end
          default: void'(q.pop_front());
        endcase
      end
      m_pending = interrupt | (m_pending & ~acc);
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog timeout cycles=%0d", cyc);
    $fatal(1);
  end

  initial begin
    int npl;
    pop_words[0] = '0;
    pop_words[1] = '0;
    reset = 1'b1;
    repeat (2) tick();
    @(negedge clk);
    chk("reset_outputs",
        64'({hold, mem_req, mem_we, mem_wdata, sp_op, flags_save, flags_restore, pc_load, pc_load_value, busy}),
        64'h0);
    tick();
    reset = 1'b0;
    repeat (3) tick();

    // Interrupt entry, zero-wait memory.
    if_pc = 32'h0001_0040;
    tick(); base = cyc; interrupt = 1'b1;
    adv(1); interrupt = 1'b0;
    go(1); chk("t1_busy_c1", 64'(busy), 64'd0);
    go(2); chk("t1_hold_c2", 64'(hold), 64'd1);
    go(5); chk("t1_push_hi", 64'({mem_req, mem_we, sp_op, mem_wdata}), 64'({1'b1, 1'b1, 2'b01, 16'h0001}));
    go(6); chk("t1_push_lo", 64'({mem_req, mem_we, sp_op, mem_wdata}), 64'({1'b1, 1'b1, 2'b01, 16'h0040}));
    go(7); chk("t1_vector", 64'({pc_load, flags_save, hold, pc_load_value}), 64'({1'b1, 1'b1, 1'b1, 32'h0000_0020}));
    go(8); chk("t1_idle", 64'({hold, busy}), 64'd0);
    repeat (3) tick();

    // RTI return.
    pop_words[0] = 16'h0040; pop_words[1] = 16'h0001; pop_idx = 0;
    tick(); base = cyc; rti_decoded = 1'b1;
    adv(1); rti_decoded = 1'b0;
    go(1); chk("t2_hold_c1", 64'(hold), 64'd1);
    go(4); chk("t2_pop_lo", 64'({mem_req, mem_we, sp_op}), 64'({1'b1, 1'b0, 2'b10}));
    go(6); chk("t2_resume", 64'({pc_load, flags_restore, flags_save, pc_load_value}), 64'({1'b1, 1'b1, 1'b0, 32'h0001_0040}));
    go(7); chk("t2_idle", 64'(busy), 64'd0);
    repeat (3) tick();

    // Branch flush defers acceptance by one cycle.
    tick(); base = cyc; interrupt = 1'b1; if_pc = 32'h0003_0000;
    adv(1); interrupt = 1'b0; branch_flush = 1'b1; if_pc = 32'h0003_0004;
    adv(2); branch_flush = 1'b0; if_pc = 32'h0005_0200;
    go(2); chk("t3_deferred", 64'(busy), 64'd0);
    go(3); chk("t3_drain", 64'(busy), 64'd1);
    go(6); chk("t3_push_hi", 64'({mem_req, mem_wdata}), 64'({1'b1, 16'h0005}));
    go(7); chk("t3_push_lo", 64'({mem_req, mem_wdata}), 64'({1'b1, 16'h0200}));
    go(8); chk("t3_vector", 64'(pc_load), 64'd1);
    repeat (3) tick();

    // PUSH_HI acknowledged after two wait cycles; if_pc moves every cycle.
    first_delay = 2;
    tick(); base = cyc; interrupt = 1'b1; if_pc = 32'h0007_0000;
    for (int k = 1; k <= 10; k++) begin
      adv(k);
      interrupt = 1'b0;
      if_pc = 32'h0007_0000 + 32'(4 * k);
      @(negedge clk);
      if (k >= 5 && k <= 7)
        chk("t4_push_hi_stable", 64'({mem_req, mem_we, sp_op, mem_wdata}), 64'({1'b1, 1'b1, 2'b01, 16'h0007}));
      if (k == 8) chk("t4_push_lo", 64'({mem_req, mem_wdata}), 64'({1'b1, 16'h0008}));
      if (k == 9) chk("t4_vector", 64'({pc_load, pc_load_value}), 64'({1'b1, 32'h0000_0020}));
      if (k == 10) chk("t4_idle", 64'(busy), 64'd0);
    end
    repeat (3) tick();

    // Three pulses during a busy sequence collapse into one more entry.
    npl = 0;
    tick(); base = cyc; interrupt = 1'b1;
    for (int k = 1; k <= 25; k++) begin
      adv(k);
      interrupt = (k == 2 || k == 3 || k == 5);
      @(negedge clk);
      if (pc_load) npl++;
      if (k == 8) chk("t5_idle_gap", 64'(busy), 64'd0);
      if (k == 9) chk("t5_reentry", 64'(busy), 64'd1);
      if (k == 14) chk("t5_vector2", 64'(pc_load), 64'd1);
      if (k == 25) chk("t5_final_idle", 64'(busy), 64'd0);
    end
    chk("t5_entries", 64'(npl), 64'd2);
    repeat (3) tick();

    // RTI and pending together: RTI first, entry right after RESUME.
    pop_words[0] = 16'h1234; pop_words[1] = 16'hABCD; pop_idx = 0;
    if_pc = 32'h0009_0010;
    tick(); base = cyc; interrupt = 1'b1;
    adv(1); interrupt = 1'b0; rti_decoded = 1'b1;
    adv(2); rti_decoded = 1'b0;
    go(5); chk("t6_pop_first", 64'({mem_req, mem_we, sp_op}), 64'({1'b1, 1'b0, 2'b10}));
    go(7); chk("t6_resume", 64'({pc_load, flags_restore, pc_load_value}), 64'({1'b1, 1'b1, 32'hABCD_1234}));
    go(8); chk("t6_idle_one", 64'(busy), 64'd0);
    go(9); chk("t6_entry", 64'(hold), 64'd1);
    go(14); chk("t6_vector", 64'({pc_load, flags_save, pc_load_value}), 64'({1'b1, 1'b1, 32'h0000_0020}));
    repeat (3) tick();

    // Reset in PUSH_LO with a further interrupt pending.
    tick(); base = cyc; interrupt = 1'b1;
    adv(1); interrupt = 1'b0;
    adv(3); interrupt = 1'b1;
    adv(4); interrupt = 1'b0;
    go(5); chk("t7_push_hi", 64'({mem_req, mem_we}), 64'({1'b1, 1'b1}));
    adv(6); reset = 1'b1;
    go(6); chk("t7_reset_outputs",
               64'({hold, mem_req, mem_we, mem_wdata, sp_op, flags_save, flags_restore, pc_load, pc_load_value, busy}),
               64'h0);
    adv(7); reset = 1'b0;
    go(7); chk("t7_idle", 64'(busy), 64'd0);
    go(10); chk("t7_pending_cleared", 64'({hold, busy}), 64'd0);
    repeat (3) tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
